// File: rtl/rename_n_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rename_n_if
// Description : Decode-side, dispatch-side and commit bundle of the rename stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface rename_n_if #(
    parameter int WIDTH        = 2,
    parameter int ARCH_REGS    = 32,
    parameter int TAG_WIDTH    = 5,
    parameter int COMMIT_PORTS = 2
);
    localparam int c_aw = $clog2(ARCH_REGS);

    logic                            flush;
    logic [WIDTH-1:0]                in_valid;
    logic                            in_ready;
    logic [WIDTH*c_aw-1:0]           in_rs1;
    logic [WIDTH*c_aw-1:0]           in_rs2;
    logic [WIDTH*c_aw-1:0]           in_rd;
    logic [WIDTH-1:0]                in_has_rd;
    logic [WIDTH*TAG_WIDTH-1:0]      in_tag;
    logic [WIDTH-1:0]                out_valid;
    logic                            out_ready;
    logic [WIDTH*TAG_WIDTH-1:0]      out_rs1_tag;
    logic [WIDTH*TAG_WIDTH-1:0]      out_rs2_tag;
    logic [WIDTH-1:0]                out_rs1_busy;
    logic [WIDTH-1:0]                out_rs2_busy;
    logic [WIDTH*TAG_WIDTH-1:0]      out_dest_tag;
    logic [WIDTH*c_aw-1:0]           out_rd;
    logic [WIDTH-1:0]                out_has_rd;
    logic [COMMIT_PORTS-1:0]         commit_we;
    logic [COMMIT_PORTS*TAG_WIDTH-1:0] commit_tag;

    modport master (
        output flush, in_valid, in_rs1, in_rs2, in_rd, in_has_rd, in_tag,
               out_ready, commit_we, commit_tag,
        input  in_ready, out_valid, out_rs1_tag, out_rs2_tag, out_rs1_busy,
               out_rs2_busy, out_dest_tag, out_rd, out_has_rd
    );

    modport slave (
        input  flush, in_valid, in_rs1, in_rs2, in_rd, in_has_rd, in_tag,
               out_ready, commit_we, commit_tag,
        output in_ready, out_valid, out_rs1_tag, out_rs2_tag, out_rs1_busy,
               out_rs2_busy, out_dest_tag, out_rd, out_has_rd
    );
endinterface
`default_nettype wire

// File: rtl/rename_n.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rename_n
// Description : N-wide register rename stage with speculative alias table and
//               registered output. Define RENAME_COMPACT_EN to pack valid slots
//               toward slot 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rename_n #(
    parameter int WIDTH        = 2,
    parameter int ARCH_REGS    = 32,
    parameter int TAG_WIDTH    = 5,
    parameter int COMMIT_PORTS = 2
) (
    input wire        clk,
    input wire        rst,
    rename_n_if.slave bus
);
    localparam int c_aw = $clog2(ARCH_REGS);

    logic [c_aw-1:0]      w_rs1 [WIDTH];
    logic [c_aw-1:0]      w_rs2 [WIDTH];
    logic [c_aw-1:0]      w_rd  [WIDTH];
    logic [TAG_WIDTH-1:0] w_tag [WIDTH];
    logic [WIDTH-1:0]     w_in_valid;
    logic [WIDTH-1:0]     w_has_rd;
    logic [COMMIT_PORTS-1:0] w_commit_we;
    logic [TAG_WIDTH-1:0] w_ctag [COMMIT_PORTS];

    logic [ARCH_REGS-1:0] r_busy;
    logic [TAG_WIDTH-1:0] r_tag [ARCH_REGS];
    logic [ARCH_REGS-1:0] w_wr_en;
    logic [TAG_WIDTH-1:0] w_wr_tag [ARCH_REGS];
    logic [ARCH_REGS-1:0] w_tbl_clr;

    logic [TAG_WIDTH:0]   w_look1 [WIDTH];
    logic [TAG_WIDTH:0]   w_look2 [WIDTH];

    logic [WIDTH-1:0]     r_out_valid;
    logic [WIDTH-1:0]     r_rs1_busy;
    logic [WIDTH-1:0]     r_rs2_busy;
    logic [WIDTH-1:0]     r_has_rd;
    logic [TAG_WIDTH-1:0] r_rs1_tag  [WIDTH];
    logic [TAG_WIDTH-1:0] r_rs2_tag  [WIDTH];
    logic [TAG_WIDTH-1:0] r_dest_tag [WIDTH];
    logic [c_aw-1:0]      r_rd       [WIDTH];
    logic [WIDTH-1:0]     w_hold_clr1;
    logic [WIDTH-1:0]     w_hold_clr2;

    logic [WIDTH-1:0]     w_nxt_valid;
    logic [WIDTH-1:0]     w_nxt_rs1_busy;
    logic [WIDTH-1:0]     w_nxt_rs2_busy;
    logic [WIDTH-1:0]     w_nxt_has_rd;
    logic [TAG_WIDTH-1:0] w_nxt_rs1_tag  [WIDTH];
    logic [TAG_WIDTH-1:0] w_nxt_rs2_tag  [WIDTH];
    logic [TAG_WIDTH-1:0] w_nxt_dest_tag [WIDTH];
    logic [c_aw-1:0]      w_nxt_rd       [WIDTH];

    logic w_in_ready;
    logic w_fire;

    function automatic logic f_hit(input logic [TAG_WIDTH-1:0] t);
        logic v;
        v = 1'b0;
        for (int p = 0; p < COMMIT_PORTS; p++)
            if (w_commit_we[p] && (w_ctag[p] == t)) v = 1'b1;
        return v;
    endfunction

    // Table read, then commit bypass, then youngest older same-group writer.
    function automatic logic [TAG_WIDTH:0] f_lookup(input int slot, input logic [c_aw-1:0] rs);
        logic                 b;
        logic [TAG_WIDTH-1:0] t;
        b = r_busy[rs];
        t = r_tag[rs];
        if (b && f_hit(t)) begin
            b = 1'b0;
            t = '0;
        end
        for (int j = 0; j < WIDTH; j++)
            if ((j < slot) && w_in_valid[j] && w_has_rd[j] && (w_rd[j] == rs) && (w_rd[j] != '0)) begin
                b = 1'b1;
                t = w_tag[j];
            end
        if (rs == '0) begin
            b = 1'b0;
            t = '0;
        end
        return {b, t};
    endfunction

    assign w_in_valid  = bus.in_valid;
    assign w_has_rd    = bus.in_has_rd;
    assign w_commit_we = bus.commit_we;
    assign w_in_ready  = !bus.flush && ((r_out_valid == '0) || bus.out_ready);
    assign w_fire      = w_in_ready && (|bus.in_valid);

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_rs1_busy = r_rs1_busy;
    assign bus.out_rs2_busy = r_rs2_busy;
    assign bus.out_has_rd   = r_has_rd;

    generate
        for (genvar g = 0; g < COMMIT_PORTS; g++) begin : g_cp
            assign w_ctag[g] = bus.commit_tag[g*TAG_WIDTH +: TAG_WIDTH];
        end

        for (genvar g = 0; g < WIDTH; g++) begin : g_slot
            assign w_rs1[g] = bus.in_rs1[g*c_aw +: c_aw];
            assign w_rs2[g] = bus.in_rs2[g*c_aw +: c_aw];
            assign w_rd[g]  = bus.in_rd[g*c_aw +: c_aw];
            assign w_tag[g] = bus.in_tag[g*TAG_WIDTH +: TAG_WIDTH];

            assign w_look1[g] = f_lookup(g, w_rs1[g]);
            assign w_look2[g] = f_lookup(g, w_rs2[g]);

            assign w_hold_clr1[g] = r_rs1_busy[g] && f_hit(r_rs1_tag[g]);
            assign w_hold_clr2[g] = r_rs2_busy[g] && f_hit(r_rs2_tag[g]);

            assign bus.out_rs1_tag[g*TAG_WIDTH +: TAG_WIDTH]  = r_rs1_tag[g];
            assign bus.out_rs2_tag[g*TAG_WIDTH +: TAG_WIDTH]  = r_rs2_tag[g];
            assign bus.out_dest_tag[g*TAG_WIDTH +: TAG_WIDTH] = r_dest_tag[g];
            assign bus.out_rd[g*c_aw +: c_aw]                 = r_rd[g];
        end

        for (genvar g = 0; g < ARCH_REGS; g++) begin : g_ent
            assign w_tbl_clr[g] = r_busy[g] && f_hit(r_tag[g]);
        end
    endgenerate

    // Ascending slot order lets the highest slot win on a shared rd.
    always_comb begin
        w_wr_en = '0;
        for (int e = 0; e < ARCH_REGS; e++) w_wr_tag[e] = '0;
        for (int i = 0; i < WIDTH; i++)
            if (w_fire && w_in_valid[i] && w_has_rd[i] && (w_rd[i] != '0)) begin
                w_wr_en[w_rd[i]]  = 1'b1;
                w_wr_tag[w_rd[i]] = w_tag[i];
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            for (int e = 0; e < ARCH_REGS; e++) r_tag[e] <= '0;
        end else if (bus.flush) begin
            r_busy <= '0;
        end else begin
            for (int e = 0; e < ARCH_REGS; e++) begin
                if (w_wr_en[e]) begin
                    r_busy[e] <= 1'b1;
                    r_tag[e]  <= w_wr_tag[e];
                end else if (w_tbl_clr[e]) begin
                    r_busy[e] <= 1'b0;
                end
            end
        end
    end

    always_comb begin : p_pack
        int v_dst;
        v_dst          = 0;
        w_nxt_valid    = '0;
        w_nxt_rs1_busy = '0;
        w_nxt_rs2_busy = '0;
        w_nxt_has_rd   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_nxt_rs1_tag[i]  = '0;
            w_nxt_rs2_tag[i]  = '0;
            w_nxt_dest_tag[i] = '0;
            w_nxt_rd[i]       = '0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (w_in_valid[i]) begin
                w_nxt_valid[v_dst]    = 1'b1;
                w_nxt_rs1_busy[v_dst] = w_look1[i][TAG_WIDTH];
                w_nxt_rs1_tag[v_dst]  = w_look1[i][TAG_WIDTH-1:0];
                w_nxt_rs2_busy[v_dst] = w_look2[i][TAG_WIDTH];
                w_nxt_rs2_tag[v_dst]  = w_look2[i][TAG_WIDTH-1:0];
                w_nxt_dest_tag[v_dst] = w_tag[i];
                w_nxt_rd[v_dst]       = w_rd[i];
                w_nxt_has_rd[v_dst]   = w_has_rd[i];
            end
`ifdef RENAME_COMPACT_EN
            v_dst = v_dst + int'(w_in_valid[i]);
`else
            v_dst = v_dst + 1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= '0;
            r_rs1_busy  <= '0;
            r_rs2_busy  <= '0;
            r_has_rd    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_rs1_tag[i]  <= '0;
                r_rs2_tag[i]  <= '0;
                r_dest_tag[i] <= '0;
                r_rd[i]       <= '0;
            end
        end else if (bus.flush) begin
            r_out_valid <= '0;
        end else if (w_fire) begin
            r_out_valid <= w_nxt_valid;
            r_rs1_busy  <= w_nxt_rs1_busy;
            r_rs2_busy  <= w_nxt_rs2_busy;
            r_has_rd    <= w_nxt_has_rd;
            for (int i = 0; i < WIDTH; i++) begin
                r_rs1_tag[i]  <= w_nxt_rs1_tag[i];
                r_rs2_tag[i]  <= w_nxt_rs2_tag[i];
                r_dest_tag[i] <= w_nxt_dest_tag[i];
                r_rd[i]       <= w_nxt_rd[i];
            end
        end else if (bus.out_ready) begin
            r_out_valid <= '0;
        end else if (r_out_valid != '0) begin
            // Held group: retire sources whose producer commits meanwhile.
            for (int i = 0; i < WIDTH; i++) begin
                if (w_hold_clr1[i]) begin
                    r_rs1_busy[i] <= 1'b0;
                    r_rs1_tag[i]  <= '0;
                end
                if (w_hold_clr2[i]) begin
                    r_rs2_busy[i] <= 1'b0;
                    r_rs2_tag[i]  <= '0;
                end
            end
        end
    end
endmodule
`default_nettype wire
